// File: rtl/psum_drain.sv
// psum_drain: realigns the skewed partial-sum wavefront from the bottom PE row into whole rows and queues them.
// Latency: NUM enabled cycles from in_valid to out_valid when the queue is empty; each EN=0 cycle in between adds one.
// Backpressure: out_ready low holds the head row; a write into a full queue with no read in that cycle is dropped.
// Ports: CLK/RESET (sync, active high); EN advances the de-skew pipeline; in_valid/in_sum carry the skewed lanes;
//        out_valid/out_ready/out_row deliver aligned rows; overflow (sticky), drop_cnt (saturating), row_cnt (wrapping).
module psum_drain #(
  parameter int NUM   = 16,
  parameter int DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              EN,
  input  logic              in_valid,
  input  logic [NUM*16-1:0] in_sum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NUM*16-1:0] out_row,
  output logic              overflow,
  output logic [7:0]        drop_cnt,
  output logic [15:0]       row_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = NUM - 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // ---------------------------------------------------------------------------
  // De-skew: lane c waits NUM-1-c enabled cycles so every lane of a row lines
  // up with the last lane, which arrives NUM-1 cycles after lane 0.
  // ---------------------------------------------------------------------------
  logic [NUM*16-1:0] aligned;

  genvar c;
  generate
    for (c = 0; c < NUM; c++) begin : g_lane
      if (c == NUM - 1) begin : g_direct
        assign aligned[c*16 +: 16] = in_sum[c*16 +: 16];
      end else begin : g_delay
        localparam int D = NUM - 1 - c;
        logic [15:0] dly_q [D];
        logic [15:0] dly_d [D];

        always_comb begin
          dly_d = dly_q;
          if (EN) begin
            dly_d[0] = in_sum[c*16 +: 16];
            for (int i = 1; i < D; i++) begin
              dly_d[i] = dly_q[i-1];
            end
          end
        end

        always_ff @(posedge CLK) begin
          if (RESET) dly_q <= '{default: '0};
          else       dly_q <= dly_d;
        end

        assign aligned[c*16 +: 16] = dly_q[D-1];
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Row tag travels alongside lane 0's data; bit 0 is the newest entry.
  // ---------------------------------------------------------------------------
  logic [TW-1:0] tag_q, tag_d;
  logic          wr;

  always_comb begin
    tag_d = tag_q;
    if (EN) tag_d = TW'({tag_q, in_valid});
  end

  // A frozen pipeline must not re-write the row sitting at its output.
  assign wr = tag_q[TW-1] & EN;

  // ---------------------------------------------------------------------------
  // Output queue and status counters.
  // ---------------------------------------------------------------------------
  logic [NUM*16-1:0] mem_q [DEPTH];
  logic [NUM*16-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        drop_q, drop_d;
  logic [15:0]       rows_q, rows_d;
  logic              full, rd, we, drop;

  assign out_valid = (cnt_q != '0);

  always_comb begin
    full = (cnt_q == FULL_CNT);
    rd   = out_valid & out_ready;
    // A read in the same cycle frees the slot, so a full queue still takes the row.
    we   = wr & (~full | rd);
    drop = wr & full & ~rd;

    mem_d = mem_q;
    if (we) mem_d[wptr_q] = aligned;

    wptr_d     = we ? wptr_q + AW'(1) : wptr_q;
    rptr_d     = rd ? rptr_q + AW'(1) : rptr_q;
    cnt_d      = cnt_q + CW'(we) - CW'(rd);
    overflow_d = overflow_q | drop;
    drop_d     = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    rows_d     = rows_q + 16'(rd);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      tag_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      rows_q     <= '0;
    end else begin
      tag_q      <= tag_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      rows_q     <= rows_d;
    end
  end

  // Row storage carries no reset; its contents only matter once counted in cnt_q.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  // Zeroed while empty so stale rows never appear on the bus (e.g. right after reset).
  assign out_row  = out_valid ? mem_q[rptr_q] : '0;
  assign overflow = overflow_q;
  assign drop_cnt = drop_q;
  assign row_cnt  = rows_q;

endmodule

// File: tb/tb_psum_drain.sv
module tb_psum_drain;
  localparam int NUM   = 16;
  localparam int DEPTH = 4;
  localparam int W     = NUM * 16;

  logic         CLK, RESET, EN, in_valid, out_ready;
  logic         out_valid, overflow;
  logic [W-1:0] in_sum, out_row;
  logic [7:0]   drop_cnt;
  logic [15:0]  row_cnt;

  psum_drain #(.NUM(NUM), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .in_valid(in_valid), .in_sum(in_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .overflow(overflow), .drop_cnt(drop_cnt), .row_cnt(row_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;     // index of the cycle currently being observed / driven
  int en_idx = 0;  // count of enabled cycles; the array only advances on these

  // Reference model: rows launched per enabled-cycle index, and a plain queue
  // of rows that are waiting downstream.
  logic [W-1:0] launch [int];
  logic [W-1:0] mq [$];
  bit           m_ovf;
  int           m_drop;
  logic [15:0]  m_rows;

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] r;
    for (int c = 0; c < NUM; c++) r[c*16 +: 16] = 16'($urandom);
    return r;
  endfunction

  // A launched row becomes complete on its (NUM-1)th enabled cycle after launch.
  function automatic bit wr_due();
    return launch.exists(en_idx - (NUM - 1));
  endfunction

  task automatic drive_cycle(input logic en, input logic rdy);
    bit           m_wr, m_rd;
    logic [W-1:0] m_row;
    logic [W-1:0] v;
    int           sz;
    RESET = 1'b0; EN = en; out_ready = rdy;
    m_wr = 1'b0; m_row = '0;
    if (en) begin
      in_valid = launch.exists(en_idx);
      for (int c = 0; c < NUM; c++) begin
        if (launch.exists(en_idx - c)) begin
          v = launch[en_idx - c];
          in_sum[c*16 +: 16] = v[c*16 +: 16];
        end else begin
          in_sum[c*16 +: 16] = 16'($urandom);
        end
      end
      if (wr_due()) begin
        m_wr  = 1'b1;
        m_row = launch[en_idx - (NUM - 1)];
      end
    end else begin
      in_valid = 1'($urandom);
      in_sum   = rand_row();
    end
    sz   = mq.size();
    m_rd = (sz > 0) && rdy;
    @(posedge CLK); #1;
    cyc++;
    if (m_rd) begin
      void'(mq.pop_front());
      m_rows++;
    end
    if (m_wr) begin
      if (sz == DEPTH && !m_rd) begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end else begin
        mq.push_back(m_row);
      end
    end
    if (en) begin
      if (launch.exists(en_idx - (NUM - 1))) launch.delete(en_idx - (NUM - 1));
      en_idx++;
    end
  endtask

  task automatic apply_reset();
    RESET = 1'b1; EN = 1'($urandom); in_valid = 1'b1;
    out_ready = 1'($urandom); in_sum = rand_row();
    @(posedge CLK); #1;
    cyc++;
    RESET = 1'b0;
    mq.delete(); launch.delete();
    m_ovf = 1'b0; m_drop = 0; m_rows = '0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    n_cmp++; if (drop_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_drop_cnt got=%0d want=0", drop_cnt); end
    n_cmp++; if (row_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_row_cnt got=%0d want=0", row_cnt); end
  endtask

  task automatic test_single_row();
    int t, seen;
    logic [W-1:0] r;
    apply_reset();
    for (int c = 0; c < NUM; c++) r[c*16 +: 16] = 16'h0100 + 16'(c);
    repeat (3) drive_cycle(1'b1, 1'b0);
    t = cyc; launch[en_idx] = r; seen = -1;
    for (int k = 0; k < 40 && seen < 0; k++) begin
      drive_cycle(1'b1, 1'b0);
      if (out_valid === 1'b1) seen = cyc;
    end
    n_cmp++; if (seen != t + NUM) begin n_bad++; $display("FAIL single_latency got_cycle=%0d want_cycle=%0d", seen, t + NUM); end
    n_cmp++; if (out_row !== r) begin n_bad++; $display("FAIL single_row got=%h want=%h", out_row, r); end
    drive_cycle(1'b1, 1'b1);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_after_read_valid got=%b want=0", out_valid); end
    n_cmp++; if (row_cnt !== 16'd1) begin n_bad++; $display("FAIL single_row_cnt got=%0d want=1", row_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] rows [8];
    int t, first, got;
    apply_reset();
    drive_cycle(1'b1, 1'b1);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < NUM; c++) rows[r][c*16 +: 16] = 16'(r * 16 + c);
    rows[2][15:0]    = 16'h8000; rows[2][W-1 -: 16] = 16'hFFFF;
    rows[5][7*16 +: 16] = 16'hFFFF; rows[5][8*16 +: 16] = 16'h8000;
    t = cyc;
    for (int r = 0; r < 8; r++) launch[en_idx + r] = rows[r];
    first = -1; got = 0;
    for (int k = 0; k < 40; k++) begin
      drive_cycle(1'b1, 1'b1);
      if (out_valid === 1'b1) begin
        if (first < 0) first = cyc;
        n_cmp++;
        if (got >= 8 || cyc != first + got || out_row !== rows[got]) begin
          n_bad++; $display("FAIL b2b_row idx=%0d cycle=%0d got=%h", got, cyc, out_row);
        end
        got++;
      end
    end
    n_cmp++; if (first != t + NUM) begin n_bad++; $display("FAIL b2b_first got_cycle=%0d want_cycle=%0d", first, t + NUM); end
    n_cmp++; if (got != 8) begin n_bad++; $display("FAIL b2b_count got=%0d want=8", got); end
    n_cmp++; if (row_cnt !== 16'd8) begin n_bad++; $display("FAIL b2b_row_cnt got=%0d want=8", row_cnt); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] rows [6];
    int got;
    apply_reset();
    for (int r = 0; r < 6; r++) begin rows[r] = rand_row(); launch[en_idx + r] = rows[r]; end
    repeat (NUM + 8) drive_cycle(1'b1, 1'b0);
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got=%b want=1", overflow); end
    n_cmp++; if (drop_cnt !== 8'd2) begin n_bad++; $display("FAIL ovf_drop_cnt got=%0d want=2", drop_cnt); end
    got = 0;
    for (int k = 0; k < 6; k++) begin
      if (out_valid === 1'b1) begin
        n_cmp++;
        if (got >= 4 || out_row !== rows[got]) begin n_bad++; $display("FAIL ovf_row idx=%0d got=%h", got, out_row); end
        got++;
      end
      drive_cycle(1'b1, 1'b1);
    end
    n_cmp++; if (got != 4) begin n_bad++; $display("FAIL ovf_emitted got=%0d want=4", got); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
    n_cmp++; if (row_cnt !== 16'd4) begin n_bad++; $display("FAIL ovf_row_cnt got=%0d want=4", row_cnt); end
  endtask

  task automatic test_full_rdwr();
    logic [W-1:0] rows [6];
    int  b, got;
    logic rdy;
    apply_reset();
    b = en_idx;
    for (int r = 0; r < 6; r++) rows[r] = rand_row();
    for (int r = 0; r < 4; r++) launch[b + r] = rows[r];
    launch[b + 20] = rows[4];
    launch[b + 21] = rows[5];
    // Rows 4 and 5 complete at enabled cycles b+35 and b+36, while the queue is full.
    for (int k = 0; k < 40; k++) begin
      rdy = (en_idx == b + 35 || en_idx == b + 36);
      if (rdy) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_row !== rows[en_idx - (b + 35)]) begin
          n_bad++; $display("FAIL full_rdwr_head idx=%0d got=%h", en_idx - (b + 35), out_row);
        end
      end
      drive_cycle(1'b1, rdy);
    end
    n_cmp++; if (drop_cnt !== 8'd0) begin n_bad++; $display("FAIL full_rdwr_drop got=%0d want=0", drop_cnt); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL full_rdwr_ovf got=%b want=0", overflow); end
    got = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid === 1'b1) begin
        n_cmp++;
        if (got >= 4 || out_row !== rows[got + 2]) begin n_bad++; $display("FAIL full_rdwr_order idx=%0d got=%h", got, out_row); end
        got++;
      end
      drive_cycle(1'b1, 1'b1);
    end
    n_cmp++; if (got != 4) begin n_bad++; $display("FAIL full_rdwr_count got=%0d want=4", got); end
  endtask

  task automatic test_en_stall();
    int t, seen;
    logic [W-1:0] r;
    apply_reset();
    drive_cycle(1'b1, 1'b0);
    r = rand_row();
    t = cyc; launch[en_idx] = r; seen = -1;
    for (int k = 0; k < 40 && seen < 0; k++) begin
      drive_cycle(!(k >= 5 && k < 8), 1'b0);
      if (out_valid === 1'b1) seen = cyc;
    end
    n_cmp++; if (seen != t + NUM + 3) begin n_bad++; $display("FAIL stall_latency got_cycle=%0d want_cycle=%0d", seen, t + NUM + 3); end
    n_cmp++; if (out_row !== r) begin n_bad++; $display("FAIL stall_row got=%h want=%h", out_row, r); end
  endtask

  task automatic test_reset_midflight();
    bit leaked;
    apply_reset();
    launch[en_idx] = rand_row(); launch[en_idx + 1] = rand_row();
    repeat (NUM + 2) drive_cycle(1'b1, 1'b0);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL midrst_buffered got=%b want=1", out_valid); end
    launch[en_idx] = rand_row();
    repeat (5) drive_cycle(1'b1, 1'b0);
    apply_reset();
    n_cmp++;
    if (out_valid !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 8'd0 || row_cnt !== 16'd0 || out_row !== '0) begin
      n_bad++; $display("FAIL midrst_outputs valid=%b ovf=%b drop=%0d rows=%0d row=%h want all zero",
                        out_valid, overflow, drop_cnt, row_cnt, out_row);
    end
    leaked = 1'b0;
    for (int k = 0; k < 40; k++) begin
      drive_cycle(1'b1, 1'b1);
      if (out_valid !== 1'b0) leaked = 1'b1;
    end
    n_cmp++; if (leaked) begin n_bad++; $display("FAIL midrst_leak got=row_emerged want=none"); end
  endtask

  task automatic test_drop_saturate();
    apply_reset();
    for (int r = 0; r < 270; r++) launch[en_idx + r] = rand_row();
    repeat (270 + NUM + 2) drive_cycle(1'b1, 1'b0);
    n_cmp++; if (drop_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_drop_cnt got=%0d want=255", drop_cnt); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL sat_overflow got=%b want=1", overflow); end
  endtask

  task automatic test_random();
    logic en, rdy, exp_v;
    apply_reset();
    for (int k = 0; k < 1500; k++) begin
      en  = ($urandom % 10) < 8;
      rdy = ($urandom % 10) < ((k < 750) ? 8 : 3);
      if (en && ($urandom % 10) < 5) launch[en_idx] = rand_row();
      drive_cycle(en, rdy);
      exp_v = (mq.size() > 0);
      n_cmp++; if (out_valid !== exp_v) begin n_bad++; $display("FAIL rnd_valid cycle=%0d got=%b want=%b", cyc, out_valid, exp_v); end
      if (exp_v) begin
        n_cmp++; if (out_row !== mq[0]) begin n_bad++; $display("FAIL rnd_row cycle=%0d got=%h want=%h", cyc, out_row, mq[0]); end
      end
      n_cmp++; if (overflow !== m_ovf) begin n_bad++; $display("FAIL rnd_overflow cycle=%0d got=%b want=%b", cyc, overflow, m_ovf); end
      n_cmp++; if (drop_cnt !== 8'(m_drop)) begin n_bad++; $display("FAIL rnd_drop cycle=%0d got=%0d want=%0d", cyc, drop_cnt, m_drop); end
      n_cmp++; if (row_cnt !== m_rows) begin n_bad++; $display("FAIL rnd_row_cnt cycle=%0d got=%0d want=%0d", cyc, row_cnt, m_rows); end
    end
  endtask

  initial begin
    RESET = 1'b1; EN = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_sum = '0;
    test_reset();
    test_single_row();
    test_back_to_back();
    test_overflow();
    test_full_rdwr();
    test_en_stall();
    test_reset_midflight();
    test_drop_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/psum_drain.md
# psum_drain

Collects partial sums leaving the bottom PE row of the systolic array and de-skews them into aligned result rows. The array emits the partial sum for column c exactly c cycles after column 0, so this block delays each column to realign the diagonal wavefront. Aligned rows are buffered in a small FIFO and delivered downstream over a valid/ready handshake. It sits between the last PE row's `out_sum` bus and the result write-back logic.

## Interface
- `NUM`, 16: array columns; one 16-bit lane per column.
- `DEPTH`, 4: output FIFO depth in rows; power of two, ≥2.
- `CLK` input 1: system clock, 200 MHz.
- `RESET` input 1: synchronous, active-high reset.
- `EN` input 1: array enable; the de-skew pipeline advances only when high.
- `in_valid` input 1: column-0 lane of `in_sum` carries the first element of a result row this cycle.
- `in_sum` input NUM*16: bottom-row partial sums; column c = bits [(c+1)*16-1 : c*16], signed.
- `out_valid` output 1: `out_row` holds a valid aligned row.
- `out_ready` input 1: downstream accepts the row.
- `out_row` output NUM*16: aligned row at FIFO head; same lane order as `in_sum`.
- `overflow` output 1: sticky; at least one aligned row was dropped because the FIFO was full.
- `drop_cnt` output 8: number of dropped rows; saturates at 255.
- `row_cnt` output 16: rows accepted downstream (`out_valid && out_ready`); wraps at 2^16.

## Operation
- De-skew: lane c passes through a delay line of NUM-1-c registers. Lane NUM-1 has no delay. All registers shift only on cycles with `EN`=1.
- Valid tag: `in_valid` passes through a NUM-1-stage shift register gated by `EN`. Its output, ANDed with `EN`, is the aligned-write strobe `wr`.
- Data is passed bit-exact. There is no arithmetic, sign extension or saturation on sums.
- FIFO:
  - DEPTH entries, with read and write pointers and a count of width clog2(DEPTH)+1.
  - Write occurs on `wr` && !full.
  - Read occurs on `out_valid && out_ready`.
- Full with a simultaneous read and `wr`: both occur and the count is unchanged. The row is not dropped.
- Full, `wr`, no read: the row is discarded, `overflow` is set to 1, and `drop_cnt` increments unless it is already 255.
- Empty: `out_valid`=0. `out_ready` is ignored and pointers do not move.
- Pointers wrap modulo DEPTH.
- `out_row` is driven from the head entry. Its value is don't-care while `out_valid`=0.
- `EN`=0 freezes the de-skew pipeline and suppresses `wr`. The FIFO read side keeps operating.
- Back-to-back rows are allowed: `in_valid` may be high on consecutive `EN` cycles.

## Timing
- Reset values: the delay lines, tag shift register, pointers and count are all cleared. All outputs reset to 0: `out_valid`, `overflow`, `drop_cnt`, `row_cnt`.
- A reset during operation discards every in-flight row and every buffered row. `in_valid` high in the reset cycle is ignored.
- Latency with `EN` held high:
  - `in_valid` high at cycle t; lane c data presented at cycle t+c.
  - Row written at the edge ending cycle t+NUM-1.
  - If the FIFO was empty, `out_valid`=1 from cycle t+NUM. Latency is NUM cycles.
- If `EN` is low for k cycles inside that window, latency extends by exactly k cycles.
- `out_valid` and `out_row` are registered-state outputs, with no combinational path from `out_ready`.
- `out_valid` stays high, and `out_row` stays stable, until the handshake completes.
- Throughput: one row per cycle sustained when `out_ready` is held high.

## Test plan
- Single row: NUM=16, `EN`=1, `in_valid` pulse at t=10, lane c = 0x0100+c at cycle 10+c.
  - Required: `out_valid` rises at cycle 26 with `out_row` lane c = 0x0100+c.
  - After one `out_ready` cycle: `out_valid`=0 and `row_cnt`=1.
- Back-to-back: 8 consecutive rows, row r lane c = r*16+c, `out_ready`=1.
  - Required: 8 consecutive `out_valid` cycles starting 16 cycles after the first `in_valid`, rows in order, `row_cnt`=8.
  - Negative values (0x8000, 0xFFFF) must pass unchanged.
- Overflow: `out_ready`=0, 6 rows in with DEPTH=4.
  - Required: rows 0–3 buffered, `overflow`=1, `drop_cnt`=2.
  - Then `out_ready`=1: rows 0–3 are emitted, and `overflow` remains 1.
- Full plus simultaneous read/write: FIFO full, `out_ready`=1 in the same cycle as `wr`.
  - Required: no drop, `drop_cnt` unchanged, count stays 4, and row order is preserved.
- EN stall: drop `EN` for 3 cycles mid-wavefront.
  - Required: `out_valid` is delayed by exactly 3 cycles and lane data stays correctly aligned.
- Reset mid-flight: assert `RESET` 5 cycles after `in_valid` while 2 rows are buffered.
  - Required: the next cycle shows all outputs 0, and no row ever emerges afterwards.
